adc: RTL

Audio ADC receive controller: generates the serial-audio clocks for an external stereo ADC codec, deserializes its 64-bit frame on `sdto`, and delivers one 20-bit left/right sample pair per frame to the system through a valid/ready handshake. It is the capture-side counterpart of the `dac` controller. It uses the same clock ratios (mclk = clk/4, bclk = clk/16, lrck = clk/1024) and the same frame format, so both codecs can share one audio clock domain.

---
 rtl/audio_pkg.sv | 13 +
 rtl/adc_sync.sv | 20 ++
 rtl/adc.sv | 92 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Constants shared by the dac and adc serial-audio controllers:
// frame geometry and the timing-counter positions that mark slot boundaries.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 20;
  localparam int unsigned SLOT_W   = 32;
  localparam int unsigned FRAME_W  = 64;
  localparam int unsigned TIMING_W = 10;

  localparam logic [TIMING_W-1:0] NEXT_CNT   = 10'h1FF;
  localparam logic [TIMING_W-1:0] LEFT_START = 10'h200;

endpackage

// File: rtl/adc_sync.sv
// Single-bit multi-flop synchronizer for the asynchronous codec data line.
module adc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/adc.sv
// Audio ADC receive controller: generates mclk/bclk/lrck, deserializes the 64-bit
// codec frame and hands out 20-bit L/R pairs over valid/ready.
// Build option: define ADC_OVR_EN to drop frames and flag overrun instead of overwriting.
module adc
  import audio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  CAPT_PHASE  = 4'hB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sdto,
  output logic                mclk,
  output logic                bclk,
  output logic                lrck,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                valid,
  input  logic                ready,
  output logic                overrun,
  input  logic                ovr_clr
);

  logic [TIMING_W-1:0] timing;
  logic [FRAME_W-1:0]  sr;
  logic                sdto_s;
  logic                primed;
  logic                publish;
  logic                load;
  logic                unused_sr_msb;

  adc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sdto),
    .q   (sdto_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timing <= '0;
      sr     <= '0;
      primed <= 1'b0;
    end else begin
      timing <= timing + 1'b1;
      if (timing[3:0] == CAPT_PHASE)
        sr <= {sr[FRAME_W-2:0], sdto_s};
      // The first left slot after reset marks the start of the first complete frame.
      if (timing == LEFT_START)
        primed <= 1'b1;
    end
  end

  assign mclk    = timing[1];
  assign bclk    = timing[3];
  assign lrck    = timing[9];
  assign publish = primed && (timing == NEXT_CNT);

  assign unused_sr_msb = sr[FRAME_W-1];

`ifdef ADC_OVR_EN
  assign load = publish && (!valid || ready);

  // Set has priority over clear so a drop coinciding with ovr_clr is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              overrun <= 1'b0;
    else if (publish && valid && !ready)   overrun <= 1'b1;
    else if (ovr_clr)                      overrun <= 1'b0;
  end
`else
  logic unused_ovr_clr;

  assign load           = publish;
  assign overrun        = 1'b0;
  assign unused_ovr_clr = ovr_clr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_l <= '0;
      sample_r <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      sample_l <= sr[SLOT_W+SAMPLE_W-1:SLOT_W];
      sample_r <= sr[SAMPLE_W-1:0];
      valid    <= 1'b1;
    end else if (valid && ready) begin
      valid    <= 1'b0;
    end
  end

endmodule
